// File: rtl/spi_xfer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_xfer_pkg
//  Purpose  : Shared state encoding, R/W bit encoding and width helper for the
//             SPI slave transaction controller.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_xfer_pkg;

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        GET          = 4'd1,
        GOT          = 4'd2,
        READ_LOAD    = 4'd3,
        READ         = 4'd4,
        WRITE        = 4'd5,
        WRITE_SETTLE = 4'd6,
        COMMIT       = 4'd7,
        DONE         = 4'd8
    } state_t;

    localparam logic c_rw_read  = 1'b1;
    localparam logic c_rw_write = 1'b0;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module   : spi_bit_counter
//  Purpose  : Frame bit counter and settle-delay counter with clear, saturating
//             increment and terminal-count compare.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_bit_counter #(
    parameter int BIT_W         = 4,
    parameter int SET_W         = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bit_clr,
    input  logic             bit_inc,
    input  logic [BIT_W-1:0] bit_limit,
    input  logic             settle_clr,
    input  logic             settle_inc,
    output logic             bit_last,
    output logic             settle_done
);

    logic [BIT_W-1:0] bit_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [SET_W-1:0] settle_cnt_d;
    logic [SET_W-1:0] settle_cnt_q;

    // bit_last flags the count one short of the limit so the FSM can leave
    // the shifting state on the same clk as the final edge.
    assign bit_last    = (bit_cnt_q == (bit_limit - BIT_W'(1)));
    assign settle_done = (settle_cnt_q == SET_W'(SETTLE_CYCLES));

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (bit_clr) begin
            bit_cnt_d = '0;
        end else if (bit_inc && (bit_cnt_q != '1)) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end

        settle_cnt_d = settle_cnt_q;
        if (settle_clr) begin
            settle_cnt_d = '0;
        end else if (settle_inc && !settle_done) begin
            settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q    <= '0;
            settle_cnt_q <= '0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_xfer_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : spi_xfer_fsm
//  Purpose  : SPI slave transaction controller: command capture, read load and
//             shift-out, write commit. Optional macro SPI_XFER_FSM_ABORT_ERR_EN
//             adds a sticky abort_err output.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_xfer_fsm
    import spi_xfer_pkg::*;
#(
    parameter int ADDR_BITS     = 7,
    parameter int DATA_BITS     = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cs_n,
    input  logic sclk_pos_edge,
    input  logic sclk_neg_edge,
    input  logic rw_bit,
    output logic sr_edge,
    output logic sr_load,
    output logic addr_we,
    output logic dm_we,
    output logic miso_en,
`ifdef SPI_XFER_FSM_ABORT_ERR_EN
    output logic abort_err,
`endif
    output logic busy
);

    localparam int c_cmd_bits = ADDR_BITS + 1;
    localparam int c_max_bits = (c_cmd_bits > DATA_BITS) ? c_cmd_bits : DATA_BITS;
    localparam int c_bit_w    = clog2(c_max_bits + 1);
    localparam int c_set_w    = (SETTLE_CYCLES > 0) ? clog2(SETTLE_CYCLES + 1) : 1;

    state_t state_d, state_q;
    logic   sr_edge_d, sr_edge_q;
    logic   sr_load_d, sr_load_q;
    logic   addr_we_d, addr_we_q;
    logic   dm_we_d, dm_we_q;
    logic   miso_en_d, miso_en_q;
    logic   busy_d, busy_q;

    logic               w_bit_clr;
    logic               w_bit_inc;
    logic               w_settle_clr;
    logic               w_settle_inc;
    logic               w_bit_last;
    logic               w_settle_done;
    logic [c_bit_w-1:0] w_bit_limit;

    assign w_bit_limit = (state_q == GET) ? c_bit_w'(c_cmd_bits) : c_bit_w'(DATA_BITS);

    spi_bit_counter #(
        .BIT_W         (c_bit_w),
        .SET_W         (c_set_w),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_bit_counter (
        .clk         (clk),
        .reset_n     (reset_n),
        .bit_clr     (w_bit_clr),
        .bit_inc     (w_bit_inc),
        .bit_limit   (w_bit_limit),
        .settle_clr  (w_settle_clr),
        .settle_inc  (w_settle_inc),
        .bit_last    (w_bit_last),
        .settle_done (w_settle_done)
    );

`ifdef SPI_XFER_FSM_ABORT_ERR_EN
    logic abort_err_d, abort_err_q;
    assign abort_err = abort_err_q;
`endif

    always_comb begin
        state_d      = state_q;
        sr_edge_d    = 1'b0;
        sr_load_d    = 1'b0;
        addr_we_d    = 1'b0;
        dm_we_d      = 1'b0;
        miso_en_d    = 1'b0;
        w_bit_clr    = 1'b0;
        w_bit_inc    = 1'b0;
        w_settle_clr = 1'b0;
        w_settle_inc = 1'b0;

        // A raised chip select wins over everything, including a pending commit.
        if (cs_n) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = GET;
                    w_bit_clr = 1'b1;
                end
                GET: begin
                    if (sclk_pos_edge) begin
                        sr_edge_d = 1'b1;
                        w_bit_inc = 1'b1;
                        if (w_bit_last) begin
                            state_d      = GOT;
                            w_settle_clr = 1'b1;
                        end
                    end
                end
                GOT: begin
                    if (w_settle_done) begin
                        addr_we_d    = 1'b1;
                        w_settle_clr = 1'b1;
                        w_bit_clr    = 1'b1;
                        case (rw_bit)
                            c_rw_read:  state_d = READ_LOAD;
                            c_rw_write: state_d = WRITE;
                        endcase
                    end else begin
                        w_settle_inc = 1'b1;
                    end
                end
                READ_LOAD: begin
                    if (w_settle_done) begin
                        sr_load_d = 1'b1;
                        w_bit_clr = 1'b1;
                        state_d   = READ;
                    end else begin
                        w_settle_inc = 1'b1;
                    end
                end
                READ: begin
                    miso_en_d = 1'b1;
                    // Shift on the falling edge so the bit is stable for the master's rising sample.
                    if (sclk_neg_edge) begin
                        sr_edge_d = 1'b1;
                        w_bit_inc = 1'b1;
                        if (w_bit_last) begin
                            state_d = DONE;
                        end
                    end
                end
                WRITE: begin
                    if (sclk_pos_edge) begin
                        sr_edge_d = 1'b1;
                        w_bit_inc = 1'b1;
                        if (w_bit_last) begin
                            state_d      = WRITE_SETTLE;
                            w_settle_clr = 1'b1;
                        end
                    end
                end
                WRITE_SETTLE: begin
                    if (w_settle_done) begin
                        state_d = COMMIT;
                    end else begin
                        w_settle_inc = 1'b1;
                    end
                end
                COMMIT: begin
                    dm_we_d = 1'b1;
                    state_d = DONE;
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);

`ifdef SPI_XFER_FSM_ABORT_ERR_EN
        abort_err_d = abort_err_q;
        if (cs_n && (state_q != IDLE) && (state_q != DONE)) begin
            abort_err_d = 1'b1;
        end else if (!cs_n && (state_q == IDLE)) begin
            abort_err_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sr_edge_q   <= 1'b0;
            sr_load_q   <= 1'b0;
            addr_we_q   <= 1'b0;
            dm_we_q     <= 1'b0;
            miso_en_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SPI_XFER_FSM_ABORT_ERR_EN
            abort_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sr_edge_q   <= sr_edge_d;
            sr_load_q   <= sr_load_d;
            addr_we_q   <= addr_we_d;
            dm_we_q     <= dm_we_d;
            miso_en_q   <= miso_en_d;
            busy_q      <= busy_d;
`ifdef SPI_XFER_FSM_ABORT_ERR_EN
            abort_err_q <= abort_err_d;
`endif
        end
    end

    assign sr_edge = sr_edge_q;
    assign sr_load = sr_load_q;
    assign addr_we = addr_we_q;
    assign dm_we   = dm_we_q;
    assign miso_en = miso_en_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire
